ifetch_pc_unit: RTL and testbench

Instruction-fetch stage holding the program counter and the IF/ID pipeline register. It drives `PCPlus4` into the next-PC `mux_2to1_32bit` (inA) and consumes that mux's output as `NextPC`, with `Redirect` being the same select line. It fetches through a req/ack instruction-memory handshake and absorbs stalls, flushes, and redirects that arrive while a fetch is outstanding.

---
 rtl/ifetch_pc_unit.sv | 151 +++++++++++++++
 tb/tb_ifetch_pc_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_pc_unit.sv
// ifetch_pc_unit
// Instruction-fetch stage: owns the program counter, a one-entry skid buffer
// and the IF/ID pipeline register. Fetches through a req/ack instruction
// memory handshake and absorbs stalls, flushes and redirects that arrive
// while a fetch is outstanding.
//
// Ports
//   Clk, Reset        rising-edge clock, asynchronous active-high reset
//   NextPC            next-PC mux output (PCPlus4 or branch/jump target)
//   Redirect          taken branch/jump, also the next-PC mux select
//   Stall             decode cannot accept a new IF/ID entry
//   IMemAck/IMemData  memory returns an instruction word this cycle
//   PC, PCPlus4       current fetch address and PC+4 (to mux inA)
//   IMemReq/IMemAddr  fetch request and its address
//   IFID_*            registered instruction, its PC+4, and valid flag
module ifetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] NextPC,
    input  logic        Redirect,
    input  logic        Stall,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] IFID_Instr,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HELD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] hold_pc4, hold_pc4_nxt;
    logic [31:0] redir_pc, redir_pc_nxt;
    logic [31:0] instr_nxt, pc4_nxt;
    logic        valid_nxt;

    assign PCPlus4  = PC + 32'd4;
    assign IMemReq  = (state == REQ) || (state == DISCARD);
    // PC is frozen while a fetch is outstanding (including DISCARD), so it
    // is always the outstanding address whenever the request is up.
    assign IMemAddr = PC;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            PC           <= RESET_PC;
            hold_instr   <= '0;
            hold_pc4     <= '0;
            redir_pc     <= '0;
            IFID_Instr   <= '0;
            IFID_PCPlus4 <= '0;
            IFID_Valid   <= 1'b0;
        end else begin
            state        <= state_nxt;
            PC           <= pc_nxt;
            hold_instr   <= hold_instr_nxt;
            hold_pc4     <= hold_pc4_nxt;
            redir_pc     <= redir_pc_nxt;
            IFID_Instr   <= instr_nxt;
            IFID_PCPlus4 <= pc4_nxt;
            IFID_Valid   <= valid_nxt;
        end
    end

    // Priority inside every state: Redirect > ack > Stall.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = PC;
        hold_instr_nxt = hold_instr;
        hold_pc4_nxt   = hold_pc4;
        redir_pc_nxt   = redir_pc;
        instr_nxt      = IFID_Instr;
        pc4_nxt        = IFID_PCPlus4;
        valid_nxt      = IFID_Valid;

        case (state)
            IDLE: begin
                state_nxt = REQ;
                valid_nxt = 1'b0;
            end

            REQ: begin
                if (Redirect) begin
                    valid_nxt = 1'b0;
                    if (IMemAck) begin
                        // wrong-path data is dropped, refetch at target
                        pc_nxt = NextPC;
                    end else begin
                        // cannot retract the request: park the target
                        redir_pc_nxt = NextPC;
                        state_nxt    = DISCARD;
                    end
                end else if (IMemAck) begin
                    pc_nxt = NextPC;
                    if (!Stall) begin
                        instr_nxt = IMemData;
                        pc4_nxt   = PCPlus4;
                        valid_nxt = 1'b1;
                    end else begin
                        // decode is busy: keep the word aside, IF/ID holds
                        hold_instr_nxt = IMemData;
                        hold_pc4_nxt   = PCPlus4;
                        state_nxt      = HELD;
                    end
                end else if (!Stall) begin
                    valid_nxt = 1'b0;
                end
            end

            HELD: begin
                if (Redirect) begin
                    pc_nxt    = NextPC;
                    valid_nxt = 1'b0;
                    state_nxt = REQ;
                end else if (!Stall) begin
                    instr_nxt = hold_instr;
                    pc4_nxt   = hold_pc4;
                    valid_nxt = 1'b1;
                    state_nxt = REQ;
                end
            end

            DISCARD: begin
                valid_nxt = 1'b0;
                if (IMemAck) begin
                    // a redirect in the ack cycle is the newest target
                    pc_nxt    = Redirect ? NextPC : redir_pc;
                    state_nxt = REQ;
                end else if (Redirect) begin
                    redir_pc_nxt = NextPC;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifetch_pc_unit.sv
module tb_ifetch_pc_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] NextPC;
    logic        Redirect, Stall, IMemAck;
    logic [31:0] IMemData;
    logic [31:0] PC, PCPlus4, IMemAddr, IFID_Instr, IFID_PCPlus4;
    logic        IMemReq, IFID_Valid;

    // second instance exercising the address wrap, zero-wait memory
    logic [31:0] w_pc, w_pc4, w_addr, w_instr, w_ifpc4;
    logic        w_req, w_valid;

    always #5 Clk = ~Clk;

    ifetch_pc_unit dut (
        .Clk(Clk), .Reset(Reset), .NextPC(NextPC), .Redirect(Redirect),
        .Stall(Stall), .IMemAck(IMemAck), .IMemData(IMemData),
        .PC(PC), .PCPlus4(PCPlus4), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid)
    );

    ifetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .Clk(Clk), .Reset(Reset), .NextPC(w_pc4), .Redirect(1'b0),
        .Stall(1'b0), .IMemAck(w_req), .IMemData(32'h5A5A_0000),
        .PC(w_pc), .PCPlus4(w_pc4), .IMemReq(w_req), .IMemAddr(w_addr),
        .IFID_Instr(w_instr), .IFID_PCPlus4(w_ifpc4), .IFID_Valid(w_valid)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    ent_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          mem_lat = 1;
    int          wait_cnt = 0;
    logic        discard_pending = 1'b0;
    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: observe at negedge, model memory + scoreboard, drive.
    task automatic cycle(input logic stall, input logic redir, input logic [31:0] tgt);
        logic ack;
        ent_t e;
        @(negedge Clk);
        obs_req  = IMemReq;
        obs_addr = IMemAddr;
        ack = 1'b0;
        if (IMemReq) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                ack = 1'b1;
                wait_cnt = 0;
            end
        end
        // decode consumes the IF/ID entry when valid and not stalled;
        // a redirect flushes IF/ID and the skid buffer instead
        if (redir) begin
            sb.delete();
        end else if (IFID_Valid && !stall) begin
            if (sb.size() == 0) begin
                chk("ifid_extra", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("ifid_instr", IFID_Instr, e.instr);
                chk("ifid_pc4", IFID_PCPlus4, e.pc4);
            end
        end
        if (ack) begin
            if (redir || discard_pending) discard_pending = 1'b0;
            else sb.push_back({32'hA0 + IMemAddr, IMemAddr + 32'd4});
        end else if (redir && IMemReq) begin
            discard_pending = 1'b1;
        end
        Stall    = stall;
        Redirect = redir;
        NextPC   = redir ? tgt : PCPlus4;
        IMemAck  = ack;
        IMemData = ack ? 32'hA0 + IMemAddr : 32'hDEAD_BEEF;
    endtask

    initial begin
        Reset = 1'b1; Stall = 0; Redirect = 0; IMemAck = 0;
        NextPC = 0; IMemData = 0;
        #1;
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", {31'b0, IMemReq}, 32'd0);
        chk("rst_valid", {31'b0, IFID_Valid}, 32'd0);
        chk("rst_instr", IFID_Instr, 32'h0);
        chk("rst_ifpc4", IFID_PCPlus4, 32'h0);
        chk("w_rst_pc", w_pc, 32'hFFFF_FFFC);
        chk("w_rst_pc4", w_pc4, 32'h0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // reset and start, zero-wait memory
        cycle(0, 0, 0);                                   // c1
        chk("start_req", {31'b0, obs_req}, 32'd1);
        chk("start_addr0", obs_addr, 32'h0);
        chk("start_valid0", {31'b0, IFID_Valid}, 32'd0);
        chk("w_addr0", w_addr, 32'hFFFF_FFFC);
        cycle(0, 0, 0);                                   // c2
        chk("start_addr1", obs_addr, 32'h4);
        chk("start_valid1", {31'b0, IFID_Valid}, 32'd1);
        chk("w_addr1", w_addr, 32'h0);
        chk("w_ifpc4", w_ifpc4, 32'h0);
        chk("w_instr", w_instr, 32'h5A5A_0000);

        // stall on the ack of addr 8 for three cycles
        cycle(1, 0, 0);                                   // c3
        chk("start_addr2", obs_addr, 32'h8);
        cycle(1, 0, 0);                                   // c4: HELD
        chk("held_req", {31'b0, obs_req}, 32'd0);
        chk("held_instr", IFID_Instr, 32'hA4);
        cycle(1, 0, 0);                                   // c5
        chk("held_instr2", IFID_Instr, 32'hA4);
        chk("held_valid", {31'b0, IFID_Valid}, 32'd1);
        cycle(0, 0, 0);                                   // c6: release
        cycle(0, 0, 0);                                   // c7
        chk("resume_addr", obs_addr, 32'hC);

        // redirect together with ack
        cycle(0, 1, 32'h100);                             // c8
        mem_lat = 3;
        cycle(0, 1, 32'h200);                             // c9: redirect w/o ack
        chk("redir_valid", {31'b0, IFID_Valid}, 32'd0);
        chk("redir_addr", obs_addr, 32'h100);
        cycle(0, 1, 32'h300);                             // c10
        chk("disc_addr1", obs_addr, 32'h100);
        chk("disc_valid1", {31'b0, IFID_Valid}, 32'd0);
        cycle(0, 0, 0);                                   // c11: ack dropped
        chk("disc_addr2", obs_addr, 32'h100);
        chk("disc_valid2", {31'b0, IFID_Valid}, 32'd0);
        cycle(0, 0, 0);                                   // c12
        chk("disc_target", obs_addr, 32'h300);
        chk("disc_valid3", {31'b0, IFID_Valid}, 32'd0);
        cycle(0, 0, 0);                                   // c13
        cycle(0, 0, 0);                                   // c14: ack @0x300

        // redirect beats stall while HELD
        mem_lat = 1;
        cycle(1, 0, 0);                                   // c15: ack, stall
        chk("bubble_addr", obs_addr, 32'h304);
        cycle(1, 1, 32'h400);                             // c16: HELD + redirect
        chk("rbs_req", {31'b0, obs_req}, 32'd0);
        cycle(0, 0, 0);                                   // c17
        chk("rbs_valid", {31'b0, IFID_Valid}, 32'd0);
        chk("rbs_addr", obs_addr, 32'h400);
        cycle(0, 0, 0);                                   // c18

        // async reset in the middle of DISCARD
        mem_lat = 3;
        cycle(0, 1, 32'h500);                             // c19
        @(posedge Clk);
        #2;
        chk("pre_rst_req", {31'b0, IMemReq}, 32'd1);
        chk("pre_rst_addr", IMemAddr, 32'h408);
        Reset = 1'b1;
        #1;
        chk("arst_req", {31'b0, IMemReq}, 32'd0);
        chk("arst_pc", PC, 32'h0);
        chk("arst_valid", {31'b0, IFID_Valid}, 32'd0);
        Redirect = 0; Stall = 0; IMemAck = 0; NextPC = 0;
        sb.delete();
        discard_pending = 1'b0;
        wait_cnt = 0;
        mem_lat = 1;
        @(negedge Clk);
        Reset = 1'b0;
        cycle(0, 0, 0);
        chk("restart_addr", obs_addr, 32'h0);
        cycle(0, 0, 0);
        chk("restart_valid", {31'b0, IFID_Valid}, 32'd1);
        cycle(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
